// File: rtl/mac_job_sequencer.sv
// rtl/mac_job_sequencer.sv - dot-product job sequencer driving one clken/sload/aclr MAC
//
// Purpose:
//   Runs one multiply-accumulate unit through dot-product jobs.
//   The issuer starts a job with a pair count (len). The sequencer first spends one cycle
//   clearing the MAC feedback path. It then streams operand pairs into the MAC over a
//   valid/ready handshake, and gates the MAC with clken on every accepted pair. After the
//   last pair it captures the final sum, and it holds that sum on a valid/ready result port
//   until the result is consumed.
//
// Ports:
//   clk         in   1     clock, all state on rising edge
//   aclr        in   1     asynchronous active-high reset (shared with the MAC)
//   start       in   1     job request, accepted only in IDLE
//   len         in   LENW  operand pair count, sampled with an accepted start
//   busy        out  1     high in every state except IDLE
//   in_valid    in   1     operand pair valid
//   in_ready    out  1     pair accepted this cycle when in_valid (RUN only)
//   in_a, in_b  in   DW    operand pair
//   mac_dataa   out  DW    MAC dataa
//   mac_datab   out  DW    MAC datab
//   mac_clken   out  1     MAC clock enable
//   mac_sload   out  1     MAC accumulator reload
//   mac_result  in   ACCW  MAC adder output
//   res_valid   out  1     job result available
//   res_ready   in   1     result consumed when res_valid & res_ready
//   res_data    out  ACCW  registered job result

module mac_job_sequencer #(
  parameter int DW   = 9,
  parameter int ACCW = 19,
  parameter int LENW = 8
) (
  input  logic            clk,
  input  logic            aclr,
  input  logic            start,
  input  logic [LENW-1:0] len,
  output logic            busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  output logic [DW-1:0]   mac_dataa,
  output logic [DW-1:0]   mac_datab,
  output logic            mac_clken,
  output logic            mac_sload,
  input  logic [ACCW-1:0] mac_result,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [ACCW-1:0] res_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESULT  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [LENW-1:0] cnt;          // pairs still to be accepted in this job
  logic [LENW-1:0] cnt_nxt;
  logic [ACCW-1:0] res_data_nxt;

  // State register. aclr is shared with the MAC, so a reset mid-job drops the job
  // with no trace; the issuer has to restart it.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state    <= S_IDLE;
      cnt      <= '0;
      res_data <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      res_data <= res_data_nxt;
    end
  end

  // Next-state logic and output decode. Every output is a pure function of the state
  // (and of the operand stream in RUN), so no output adds a cycle of latency.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    res_data_nxt = res_data;
    busy         = 1'b1;
    in_ready     = 1'b0;
    res_valid    = 1'b0;
    mac_clken    = 1'b0;
    mac_sload    = 1'b0;
    mac_dataa    = '0;
    mac_datab    = '0;

    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (len != '0) begin
            cnt_nxt   = len;
            state_nxt = S_CLEAR;
          end else begin
            // An empty job never touches the MAC; the result is simply zero.
            res_data_nxt = '0;
            state_nxt    = S_RESULT;
          end
        end
      end

      S_CLEAR: begin
        // The MAC registers sload internally. Clocking it once here, with zero operands,
        // makes the first real beat load its product instead of adding it to the sum
        // left over from the previous job.
        mac_clken = 1'b1;
        mac_sload = 1'b1;
        state_nxt = S_RUN;
      end

      S_RUN: begin
        in_ready  = 1'b1;
        mac_dataa = in_a;
        mac_datab = in_b;
        // A bubble (in_valid low) freezes both the MAC and the pair count for as
        // long as it lasts.
        mac_clken = in_valid;
        if (in_valid) begin
          cnt_nxt = cnt - LENW'(1);
          if (cnt == LENW'(1)) begin
            state_nxt = S_CAPTURE;
          end
        end
      end

      S_CAPTURE: begin
        // The last beat was clocked into the MAC on the previous edge, so the adder
        // output is now the settled final sum.
        res_data_nxt = mac_result;
        state_nxt    = S_RESULT;
      end

      S_RESULT: begin
        res_valid = 1'b1;
        // A start seen here is dropped, not queued; the issuer retries once IDLE.
        if (res_ready) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// tb/tb_mac_job_sequencer.sv - directed self-checking bench for mac_job_sequencer
module tb_mac_job_sequencer;

  localparam int DW   = 9;
  localparam int ACCW = 19;
  localparam int LENW = 8;

  logic            clk = 1'b0;
  logic            aclr = 1'b1;
  logic            start = 1'b0;
  logic [LENW-1:0] len = '0;
  logic            busy;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_a = '0;
  logic [DW-1:0]   in_b = '0;
  logic [DW-1:0]   mac_dataa;
  logic [DW-1:0]   mac_datab;
  logic            mac_clken;
  logic            mac_sload;
  logic [ACCW-1:0] mac_result;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [ACCW-1:0] res_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mac_job_sequencer #(.DW(DW), .ACCW(ACCW), .LENW(LENW)) dut (
    .clk        (clk),
    .aclr       (aclr),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mac_dataa  (mac_dataa),
    .mac_datab  (mac_datab),
    .mac_clken  (mac_clken),
    .mac_sload  (mac_sload),
    .mac_result (mac_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data)
  );

  // MAC model: the sload flag is registered inside the MAC and takes effect on the next
  // enabled clock, where it replaces the accumulator feedback with zero.
  logic [ACCW-1:0] acc;
  logic            sl_q;
  logic [2*DW-1:0] prod;
  assign prod = {{DW{1'b0}}, mac_dataa} * {{DW{1'b0}}, mac_datab};
  always @(posedge clk or posedge aclr) begin
    if (aclr) begin
      acc  <= '0;
      sl_q <= 1'b0;
    end else if (mac_clken) begin
      sl_q <= mac_sload;
      acc  <= (sl_q ? '0 : acc) + ACCW'(prod);
    end
  end
  assign mac_result = acc;

  int clken_cnt = 0;
  int sload_cnt = 0;
  always @(negedge clk) begin
    if (!aclr) begin
      if (mac_clken) clken_cnt++;
      if (mac_sload) sload_cnt++;
    end
  end

  int ja[8];
  int jb[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a job and streams ja/jb with `gap` idle cycles after each beat.
  // lat = clock edges after the start-accepting edge until res_valid is seen.
  task automatic feed_job(input int n, input int gap, output int lat,
                          output int bubbles, output int bub_hi);
    int  i;
    int  g;
    logic took;
    i = 0; g = 0; bubbles = 0; bub_hi = 0;
    start = 1'b1;
    len   = LENW'(n);
    tick();
    start = 1'b0;
    lat   = 0;
    while (lat < 200) begin
      if (res_valid) break;
      in_valid = 1'b0;
      if (in_ready && i < n) begin
        if (g > 0) begin
          g--;
          bubbles++;
        end else begin
          in_valid = 1'b1;
          in_a = DW'(ja[i]);
          in_b = DW'(jb[i]);
        end
      end
      #1;
      if (in_ready && !in_valid && mac_clken) bub_hi++;
      took = in_valid && in_ready;
      tick();
      lat++;
      if (took) begin
        i++;
        g = gap;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic load_job1();
    ja[0] = 2; jb[0] = 3;
    ja[1] = 4; jb[1] = 5;
    ja[2] = 1; jb[2] = 7;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    total++; if (mac_clken !== 1'b0) begin bad++; $display("FAIL reset_clken got=%b want=0", mac_clken); end
    total++; if (mac_sload !== 1'b0) begin bad++; $display("FAIL reset_sload got=%b want=0", mac_sload); end
    total++; if (mac_dataa !== '0 || mac_datab !== '0) begin bad++; $display("FAIL reset_data got=%0d/%0d want=0/0", mac_dataa, mac_datab); end
    total++; if (res_data !== '0)    begin bad++; $display("FAIL reset_res_data got=%0d want=0", res_data); end
    aclr = 1'b0;
    tick();
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_single();
    int lat, bub, bh, c0, s0;
    load_job1();
    c0 = clken_cnt; s0 = sload_cnt;
    feed_job(3, 0, lat, bub, bh);
    total++; if (lat !== 5)          begin bad++; $display("FAIL single_latency got=%0d want=5", lat); end
    total++; if (res_data !== 19'd33) begin bad++; $display("FAIL single_sum got=%0d want=33", res_data); end
    total++; if (clken_cnt - c0 !== 4) begin bad++; $display("FAIL single_clken_cycles got=%0d want=4", clken_cnt - c0); end
    total++; if (sload_cnt - s0 !== 1) begin bad++; $display("FAIL single_sload_cycles got=%0d want=1", sload_cnt - s0); end
    consume();
  endtask

  task automatic test_isolation();
    int lat, bub, bh;
    load_job1();
    feed_job(3, 0, lat, bub, bh);
    total++; if (res_data !== 19'd33) begin bad++; $display("FAIL iso_first got=%0d want=33", res_data); end
    consume();
    ja[0] = 3; jb[0] = 3;
    feed_job(1, 0, lat, bub, bh);
    total++; if (res_data !== 19'd9) begin bad++; $display("FAIL iso_second got=%0d want=9", res_data); end
    total++; if (lat !== 3)          begin bad++; $display("FAIL iso_latency got=%0d want=3", lat); end
    consume();
  endtask

  task automatic test_bubbles();
    int lat, bub, bh;
    load_job1();
    feed_job(3, 2, lat, bub, bh);
    total++; if (res_data !== 19'd33) begin bad++; $display("FAIL bubble_sum got=%0d want=33", res_data); end
    total++; if (lat !== 9)          begin bad++; $display("FAIL bubble_latency got=%0d want=9", lat); end
    total++; if (bub !== 4)          begin bad++; $display("FAIL bubble_count got=%0d want=4", bub); end
    total++; if (bh !== 0)           begin bad++; $display("FAIL bubble_clken got=%0d want=0", bh); end
    consume();
  endtask

  task automatic test_zero_len();
    int lat, bub, bh, c0, s0;
    c0 = clken_cnt; s0 = sload_cnt;
    feed_job(0, 0, lat, bub, bh);
    total++; if (lat !== 0)          begin bad++; $display("FAIL zero_latency got=%0d want=0", lat); end
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL zero_valid got=%b want=1", res_valid); end
    total++; if (res_data !== '0)    begin bad++; $display("FAIL zero_data got=%0d want=0", res_data); end
    consume();
    total++; if (clken_cnt - c0 !== 0 || sload_cnt - s0 !== 0) begin
      bad++; $display("FAIL zero_mac_touched got=%0d/%0d want=0/0", clken_cnt - c0, sload_cnt - s0);
    end
  endtask

  task automatic test_hold();
    int lat, bub, bh;
    load_job1();
    feed_job(3, 0, lat, bub, bh);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      len   = 8'd1;
      #1;
      total++; if (res_valid !== 1'b1 || busy !== 1'b1 || res_data !== 19'd33) begin
        bad++; $display("FAIL hold_cycle%0d got=v%b b%b d%0d want=v1 b1 d33", k, res_valid, busy, res_data);
      end
      tick();
    end
    start = 1'b0;
    consume();
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release got=b%b v%b want=b0 v0", busy, res_valid);
    end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_start_queued got=%b want=0", busy); end
  endtask

  task automatic test_abort();
    int lat, bub, bh;
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1; in_a = 9'd2; in_b = 9'd3;
    tick();
    in_valid = 1'b0;
    aclr = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL abort_flags got=b%b r%b v%b want=0 0 0", busy, in_ready, res_valid);
    end
    total++; if (mac_clken !== 1'b0 || mac_sload !== 1'b0) begin
      bad++; $display("FAIL abort_mac_ctl got=%b/%b want=0/0", mac_clken, mac_sload);
    end
    total++; if (mac_dataa !== '0 || mac_datab !== '0 || res_data !== '0) begin
      bad++; $display("FAIL abort_data got=%0d/%0d/%0d want=0/0/0", mac_dataa, mac_datab, res_data);
    end
    tick();
    aclr = 1'b0;
    tick();
    ja[0] = 5; jb[0] = 5;
    ja[1] = 1; jb[1] = 1;
    feed_job(2, 0, lat, bub, bh);
    total++; if (res_data !== 19'd26) begin bad++; $display("FAIL abort_fresh_sum got=%0d want=26", res_data); end
    total++; if (lat !== 4)           begin bad++; $display("FAIL abort_fresh_latency got=%0d want=4", lat); end
    consume();
  endtask

  initial begin
    test_reset();
    test_single();
    test_isolation();
    test_bubbles();
    test_zero_len();
    test_hold();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
